// File: rtl/reaction_bcd_encoder.sv
// Reaction-timer trial sequencer: arms a fixed delay, lights the stimulus, then counts
// elapsed ticks as two BCD digits until stop, overflow or a foul, and holds the result.
module reaction_bcd_encoder #(
  parameter int TICK_DIV    = 500000,
  parameter int DELAY_TICKS = 150
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic       read,
  output logic       stim,
  output logic       foul,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TIMING,
    RESULT
  } state_t;

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]    DELAY_LOAD = 16'(DELAY_TICKS);

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [15:0]   delay, delay_next;
  logic [3:0]    c_next, d_next;
  logic          read_next, stim_next, foul_next, overflow_next;
  logic          start_q, stop_q, start_e, stop_e;
  logic          tick;

  // Edge history resets high so a button held through reset needs a release before it counts.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      start_e <= 1'b0;
      stop_e  <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      start_e <= start & ~start_q;
      stop_e  <= stop & ~stop_q;
    end
  end

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    state_next    = state;
    delay_next    = delay;
    c_next        = c;
    d_next        = d;
    foul_next     = foul;
    overflow_next = overflow;
    presc_next    = tick ? '0 : presc + 1'b1;

    unique case (state)
      IDLE: begin
        if (start_e) begin
          state_next    = ARMED;
          delay_next    = DELAY_LOAD;
          c_next        = 4'd0;
          d_next        = 4'd0;
          foul_next     = 1'b0;
          overflow_next = 1'b0;
        end
      end

      // A stop arriving with the last delay tick is still a foul.
      ARMED: begin
        if (stop_e) begin
          state_next = RESULT;
          foul_next  = 1'b1;
          c_next     = 4'hF;
          d_next     = 4'hF;
        end else if (tick) begin
          if (delay <= 16'd1) begin
            state_next = TIMING;
            delay_next = 16'd0;
          end else begin
            delay_next = delay - 16'd1;
          end
        end
      end

      // Stop beats a coincident tick, so the displayed count is never one too high.
      TIMING: begin
        if (stop_e) begin
          state_next = RESULT;
        end else if (tick) begin
          if (c == 4'd9 && d == 4'd9) begin
            state_next    = RESULT;
            overflow_next = 1'b1;
          end else if (c == 4'd9) begin
            c_next = 4'd0;
            d_next = d + 4'd1;
          end else begin
            c_next = c + 4'd1;
          end
        end
      end

      RESULT: begin
        if (start_e) begin
          state_next    = ARMED;
          delay_next    = DELAY_LOAD;
          c_next        = 4'd0;
          d_next        = 4'd0;
          foul_next     = 1'b0;
          overflow_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state) begin
      presc_next = '0;
    end

    read_next = (state_next == RESULT);
    stim_next = (state_next == TIMING);
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      delay    <= 16'd0;
      c        <= 4'd0;
      d        <= 4'd0;
      read     <= 1'b0;
      stim     <= 1'b0;
      foul     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      presc    <= presc_next;
      delay    <= delay_next;
      c        <= c_next;
      d        <= d_next;
      read     <= read_next;
      stim     <= stim_next;
      foul     <= foul_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_reaction_bcd_encoder.sv
// Directed bench for reaction_bcd_encoder with a short tick (4) and delay (3) so whole
// trials, fouls, collisions and the 99-tick overflow fit in a few hundred cycles.
module tb_reaction_bcd_encoder;

  logic       clk50M;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] c;
  logic [3:0] d;
  logic       read;
  logic       stim;
  logic       foul;
  logic       overflow;

  int testsRun;
  int testsFailed;

  reaction_bcd_encoder #(
    .TICK_DIV   (4),
    .DELAY_TICKS(3)
  ) dut (
    .clk50M  (clk50M),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .c       (c),
    .d       (d),
    .read    (read),
    .stim    (stim),
    .foul    (foul),
    .overflow(overflow)
  );

  initial clk50M = 1'b0;
  always #5 clk50M = ~clk50M;

  task automatic applyStimulus(input logic startIn, input logic stopIn);
    start = startIn;
    stop  = stopIn;
  endtask

  // Packs outputs as {c, d, read, stim, foul, overflow}.
  task automatic checkOutput(input string tag, input logic [3:0] ec, input logic [3:0] ed,
                             input logic er, input logic es, input logic ef, input logic eo);
    logic [11:0] observed;
    logic [11:0] expected;
    observed = {c, d, read, stim, foul, overflow};
    expected = {ec, ed, er, es, ef, eo};
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed c,d,r,s,f,o=%h expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitStim(input int budget);
    int n;
    n = 0;
    while (stim !== 1'b1 && n < budget) begin
      @(negedge clk50M);
      n++;
    end
    testsRun++;
    assert (stim === 1'b1)
    else begin
      testsFailed++;
      $error("[TB] FAIL waitStim: observed stim=%b expected 1 within %0d cycles", stim, budget);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk50M);
    checkOutput("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk50M);

    // Stop in IDLE does nothing.
    applyStimulus(1'b0, 1'b1);
    repeat (4) @(negedge clk50M);
    checkOutput("idle_stop", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk50M);

    // Normal trial: stimulus 14 cycles after start rises, stop after 23 ticks.
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk50M);
    applyStimulus(1'b0, 1'b0);
    repeat (11) @(negedge clk50M);
    checkOutput("armed_pre_stim", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("stim_on", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clk50M);
    checkOutput("carry_10", 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (52) @(negedge clk50M);
    checkOutput("count_23", 4'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk50M);
    checkOutput("stop_latency", 4'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("normal_result", 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (10) @(negedge clk50M);
    checkOutput("result_hold", 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart from RESULT, with start pulses during ARMED and TIMING that must be ignored.
    applyStimulus(1'b1, 1'b0);
    @(negedge clk50M);
    checkOutput("restart_latency", 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("restart_clear", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk50M);
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk50M);
    applyStimulus(1'b0, 1'b0);
    repeat (7) @(negedge clk50M);
    checkOutput("restart_armed", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("restart_stim", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk50M);
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk50M);
    applyStimulus(1'b0, 1'b0);

    // Stop edge coincides with the tick that would take 0,7 to 0,8.
    repeat (23) @(negedge clk50M);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk50M);
    checkOutput("pre_collision", 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("collision", 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk50M);

    // Foul: stop 5 cycles after start.
    applyStimulus(1'b1, 1'b0);
    repeat (5) @(negedge clk50M);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk50M);
    checkOutput("foul_pre", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("foul", 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk50M);

    // Foul when the stop edge lands on the final ARMED tick.
    applyStimulus(1'b1, 1'b0);
    repeat (12) @(negedge clk50M);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk50M);
    checkOutput("final_tick_pre", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("foul_final_tick", 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk50M);

    // Overflow: no stop, the 100th tick ends the trial at 9,9.
    applyStimulus(1'b1, 1'b0);
    @(negedge clk50M);
    applyStimulus(1'b0, 1'b0);
    waitStim(30);
    repeat (399) @(negedge clk50M);
    checkOutput("pre_overflow", 4'd9, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("overflow", 4'd9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-TIMING with both buttons held.
    applyStimulus(1'b1, 1'b0);
    @(negedge clk50M);
    waitStim(30);
    repeat (10) @(negedge clk50M);
    applyStimulus(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk50M);
    rst_n = 1'b1;
    repeat (20) @(negedge clk50M);
    checkOutput("post_reset_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk50M);
    applyStimulus(1'b1, 1'b0);
    repeat (13) @(negedge clk50M);
    checkOutput("rearm_pre_stim", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk50M);
    checkOutput("rearm_stim", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
